lsu_mem_master: RTL and testbench

- Processor-side load/store initiator that drives the data-memory port: addr/data/size/we/re.
- Accepts one load or store request at a time over a valid/ready handshake.
- Checks alignment and region, then sequences the memory access:
  - memory latches read data on the negative clock edge;
  - memory commits writes on the positive clock edge.
- Returns aligned, sign- or zero-extended load data, or an error, as a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_load_align.sv | 29 ++
 rtl/lsu_mem_master.sv | 155 +++++++++++++++
 tb/tb_lsu_mem_master.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size codes, FSM states and alignment helper
// for the load/store memory master.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_UNAL = 2'd2;
   localparam logic [1:0] SZ_WORD = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } lsu_state_t;

   function automatic logic misaligned(
      input logic [1:0] size,
      input logic [1:0] lo
   );
      return (size == SZ_UNAL)
          || (size == SZ_HALF && lo[0])
          || (size == SZ_WORD && lo != 2'b00);
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed lane out of a memory word
// and sign- or zero-extends it to 32 bits.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_signed,
   output logic [31:0] result
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
   assign lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];

   // Extend the selected lane; words pass straight through.
   always_comb begin
      result = rdata;
      case (size)
         SZ_BYTE: result = {{24{is_signed & lane_b[7]}}, lane_b};
         SZ_HALF: result = {{16{is_signed & lane_h[15]}}, lane_h};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: one-at-a-time load/store initiator for the data
// memory port. Optional counters under LSU_STATS_EN.
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter logic [15:0] MEM_ADDR  = 16'h1000,
   parameter int unsigned READ_WAIT = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  mem_size,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [31:0] mem_rdata,
   output logic [31:0] load_count,
   output logic [31:0] store_count,
   output logic [31:0] err_count
);

   localparam logic [2:0] WAIT_LAST =
      (READ_WAIT == 0) ? 3'd0 : 3'(READ_WAIT - 1);

   lsu_state_t  state, state_nxt;
   logic        lat_we;
   logic        lat_signed;
   logic [2:0]  wait_cnt;
   logic        req_err;
   logic        accept;
   logic        capture;
   logic [31:0] aligned;

   assign req_err = misaligned(req_size, req_addr[1:0])
                 || (req_addr[31:16] != MEM_ADDR);

   lsu_load_align u_align (
      .rdata     (mem_rdata),
      .addr_lo   (mem_addr[1:0]),
      .size      (mem_size),
      .is_signed (lat_signed),
      .result    (aligned)
   );

   // State register; reset also kills any strobe driven from ISSUE.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and the handshake / memory strobes.
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      accept    = 1'b0;
      capture   = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = req_err ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            mem_we = lat_we;
            mem_re = !lat_we;
            if (lat_we || READ_WAIT == 0) begin
               capture   = !lat_we;
               state_nxt = RESP;
            end else begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            mem_re = 1'b1;
            if (wait_cnt == WAIT_LAST) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, memory-side address/data and load capture.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lat_we     <= 1'b0;
         lat_signed <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_rdata  <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_size   <= '0;
         wait_cnt   <= '0;
      end else begin
         if (accept) begin
            lat_we     <= req_we;
            lat_signed <= req_signed;
            rsp_err    <= req_err;
            rsp_rdata  <= '0;
            if (!req_err) begin
               mem_addr  <= req_addr;
               mem_wdata <= req_wdata;
               mem_size  <= req_size;
            end
         end
         if (capture) rsp_rdata <= aligned;
         if (state == ISSUE)     wait_cnt <= '0;
         else if (state == WAIT) wait_cnt <= wait_cnt + 3'd1;
      end
   end

`ifdef LSU_STATS_EN
   // Saturating per-class response counters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         load_count  <= '0;
         store_count <= '0;
         err_count   <= '0;
      end else if (state == RESP) begin
         if (rsp_err) begin
            if (err_count != '1) err_count <= err_count + 32'd1;
         end else if (lat_we) begin
            if (store_count != '1) store_count <= store_count + 32'd1;
         end else begin
            if (load_count != '1) load_count <= load_count + 32'd1;
         end
      end
   end
`else
   assign load_count  = '0;
   assign store_count = '0;
   assign err_count   = '0;
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: random + directed scoreboard bench with a
// byte-level reference memory and a negedge-read/posedge-write RAM.
module tb_lsu_mem_master;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = '0;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  mem_size;
   logic        mem_we, mem_re;
   logic [31:0] load_count, store_count, err_count;

   lsu_mem_master #(.MEM_ADDR(16'h1000), .READ_WAIT(0)) u0 (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_size(mem_size), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata),
      .load_count(load_count), .store_count(store_count),
      .err_count(err_count)
   );

   logic        req_valid_2 = 1'b0;
   logic        req_ready_2;
   logic [31:0] req_addr_2 = '0;
   logic        rsp_valid_2;
   logic [31:0] rsp_rdata_2;
   logic        rsp_err_2;
   logic [31:0] mem_addr_2, mem_wdata_2, mem_rdata_2;
   logic [1:0]  mem_size_2;
   logic        mem_we_2, mem_re_2;
   logic [31:0] load_count_2, store_count_2, err_count_2;

   lsu_mem_master #(.MEM_ADDR(16'h1000), .READ_WAIT(2)) u2 (
      .clock(clock), .reset(reset),
      .req_valid(req_valid_2), .req_ready(req_ready_2),
      .req_we(1'b0), .req_size(2'd3),
      .req_signed(1'b0), .req_addr(req_addr_2),
      .req_wdata(32'h0),
      .rsp_valid(rsp_valid_2), .rsp_rdata(rsp_rdata_2),
      .rsp_err(rsp_err_2),
      .mem_addr(mem_addr_2), .mem_wdata(mem_wdata_2),
      .mem_size(mem_size_2), .mem_we(mem_we_2), .mem_re(mem_re_2),
      .mem_rdata(mem_rdata_2),
      .load_count(load_count_2), .store_count(store_count_2),
      .err_count(err_count_2)
   );

   // Data RAM for u0: read latched on negedge, write on posedge.
   logic [31:0] mem [0:255];
   always @(negedge clock)
      if (mem_re) mem_rdata <= mem[mem_addr[9:2]];
   always @(posedge clock)
      if (mem_we)
         case (mem_size)
            2'd0: mem[mem_addr[9:2]][{mem_addr[1:0], 3'b000} +: 8]
                     <= mem_wdata[7:0];
            2'd1: mem[mem_addr[9:2]][{mem_addr[1], 4'b0000} +: 16]
                     <= mem_wdata[15:0];
            default: mem[mem_addr[9:2]] <= mem_wdata;
         endcase

   // Pattern RAM for u2 (read-only).
   always @(negedge clock)
      if (mem_re_2) mem_rdata_2 <= mem_addr_2 ^ 32'h5A5A0000;

   // Reference model: plain byte array for the 1 KB window.
   logic [7:0] ref_b [0:1023];

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          due;
      int          n_re;
      int          n_we;
   } exp_t;
   exp_t q[$];

   int exp_ld = 0, exp_st = 0, exp_er = 0;
   int re_n = 0, we_n = 0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s act=%h want=%h t=%0t", nm, act, want, $time);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      @(negedge clock);
      while (!req_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk("ready_wait", {31'b0, req_ready}, 32'd1);
   endtask

   task automatic send(input logic we, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] wd);
      exp_t e;
      int off;
      logic [31:0] v;
      bit err;
      wait_ready();
      err = (sz == 2) || (sz == 1 && a % 2 != 0)
         || (sz == 3 && a % 4 != 0) || (a / 65536 != 32'h1000);
      off = int'(a % 1024);
      v = 0;
      if (!err && we) begin
         ref_b[off] = wd[7:0];
         if (sz != 0) ref_b[off+1] = wd[15:8];
         if (sz == 3) begin
            ref_b[off+2] = wd[23:16];
            ref_b[off+3] = wd[31:24];
         end
      end else if (!err) begin
         if (sz == 0) begin
            v = 32'(ref_b[off]);
            if (sg && v >= 128) v = v - 256;
         end else if (sz == 1) begin
            v = 32'(ref_b[off]) + 256 * 32'(ref_b[off+1]);
            if (sg && v >= 32768) v = v - 65536;
         end else begin
            v = {ref_b[off+3], ref_b[off+2], ref_b[off+1], ref_b[off]};
         end
      end
      e.err  = err;
      e.data = v;
      e.due  = cyc + (err ? 1 : 2);
      e.n_re = (!err && !we) ? 1 : 0;
      e.n_we = (!err && we) ? 1 : 0;
      req_we     = we;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      req_valid  = 1'b1;
      q.push_back(e);
      @(posedge clock);
      #1 req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk("drain", q.size(), 32'd0);
   endtask

   // Monitor: pop and compare on every response pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset) begin
            if (mem_re) re_n++;
            if (mem_we) we_n++;
            if (rsp_valid) begin
               if (q.size() == 0) begin
                  chk("unexpected_rsp", 32'd1, 32'd0);
               end else begin
                  e = q.pop_front();
                  chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                  chk("rsp_rdata", rsp_rdata, e.data);
                  chk("rsp_cycle", cyc, e.due);
                  chk("mem_re_cnt", re_n, e.n_re);
                  chk("mem_we_cnt", we_n, e.n_we);
                  if (e.err) exp_er++;
                  else if (e.n_we != 0) exp_st++;
                  else exp_ld++;
               end
               re_n = 0;
               we_n = 0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1);
   end

   initial begin
      logic [31:0] w;
      int c, lat, rn;
      bit got;
      for (int i = 0; i < 256; i++) begin
         w = $urandom;
         mem[i] = w;
         for (int k = 0; k < 4; k++) ref_b[4*i+k] = w[8*k +: 8];
      end

      #12;
      chk("rst_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst_mem_re", {31'b0, mem_re}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_size", {30'b0, mem_size}, 32'd0);
      @(negedge clock);
      reset = 1'b1;

      send(1, 3, 0, 32'h1000_0010, 32'hDEADBEEF);
      send(0, 3, 0, 32'h1000_0010, 32'h0);
      send(1, 0, 0, 32'h1000_0013, 32'h0000_0080);
      send(0, 0, 1, 32'h1000_0013, 32'h0);
      send(0, 0, 0, 32'h1000_0013, 32'h0);
      send(0, 3, 0, 32'h1000_0010, 32'h0);
      send(0, 1, 0, 32'h1000_0011, 32'h0);
      send(1, 2, 0, 32'h1000_0010, 32'h5555_5555);
      send(1, 3, 0, 32'h2000_0000, 32'h1111_1111);
      send(0, 3, 0, 32'h2000_0000, 32'h0);
      send(0, 3, 0, 32'h1000_0000, 32'h0);
      send(0, 3, 0, 32'h1000_0010, 32'h0);
      drain();
      chk("word_after_byte", mem[4], 32'h80ADBEEF);

      // Reset during the ISSUE cycle of a store.
      mem[8] = 32'hADADADAD;
      for (int k = 0; k < 4; k++) ref_b[32+k] = 8'hAD;
      wait_ready();
      req_we = 1'b1;
      req_size = 2'd3;
      req_signed = 1'b0;
      req_addr = 32'h1000_0020;
      req_wdata = 32'h1234_5678;
      req_valid = 1'b1;
      @(posedge clock);
      #1 req_valid = 1'b0;
      chk("issue_we", {31'b0, mem_we}, 32'd1);
      #1 reset = 1'b0;
      #1 chk("rst_we_drop", {31'b0, mem_we}, 32'd0);
      @(posedge clock);
      #1 chk("rst_mem_kept", mem[8], 32'hADADADAD);
      @(negedge clock);
      reset = 1'b1;
      exp_ld = 0;
      exp_st = 0;
      exp_er = 0;
      re_n = 0;
      we_n = 0;
      #1 chk("rst_ready_after", {31'b0, req_ready}, 32'd1);
      send(0, 3, 0, 32'h1000_0020, 32'h0);

      for (int i = 0; i < 80; i++) begin
         logic [31:0] a;
         a = (($urandom % 8) == 0) ? 32'h2000_0000 : 32'h1000_0000;
         a = a | ($urandom % 1024);
         send(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2),
              a, $urandom);
      end
      drain();
      @(negedge clock);
`ifdef LSU_STATS_EN
      chk("load_count", load_count, exp_ld);
      chk("store_count", store_count, exp_st);
      chk("err_count", err_count, exp_er);
`else
      chk("load_count", load_count, 32'd0);
      chk("store_count", store_count, 32'd0);
      chk("err_count", err_count, 32'd0);
`endif

      // READ_WAIT=2 instance: latency and read-enable duration.
      c = cyc;
      req_addr_2 = 32'h1000_0040;
      req_valid_2 = 1'b1;
      @(posedge clock);
      #1 req_valid_2 = 1'b0;
      lat = -1;
      rn = 0;
      got = 0;
      for (int n = 0; n < 12 && !got; n++) begin
         @(negedge clock);
         if (mem_re_2) rn++;
         if (rsp_valid_2) begin
            got = 1;
            lat = cyc - c;
            chk("rw2_rdata", rsp_rdata_2, 32'h1000_0040 ^ 32'h5A5A0000);
            chk("rw2_err", {31'b0, rsp_err_2}, 32'd0);
         end
      end
      chk("rw2_latency", lat, 32'd4);
      chk("rw2_re_cycles", rn, 32'd3);
      @(negedge clock);
`ifdef LSU_STATS_EN
      chk("rw2_load_count", load_count_2, 32'd1);
`else
      chk("rw2_load_count", load_count_2, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
